csr_w2_merge: RTL
=================

Name: csr_w2_merge

Overview:
- Merges single-cycle CSR result-write pulses from several asynchronous engines onto regcsr's secondary write port (w2).
- Sources include math24_async and future timer/DMA engines.
- Engines cannot stall, so every source gets a small private FIFO.
- A round-robin drain issues at most one w2 write per cycle. Sits directly between the engines' ow_csr_* outputs and regcsr's iw_w2_* inputs.

Parameters:
- NUM_SRC, 2, number of write sources (1..8).
- DEPTH, 4, entries per source FIFO (power of two, 2..16).

Ports:
- iw_clk  in  1  clock. Single clock domain; all logic runs on its rising edge.
- iw_rst_n  in  1  reset, asynchronous assert, active-low.
- iw_src_wen  in  NUM_SRC  per-source write pulse.
- iw_src_waddr  in  NUM_SRC*(`HBIT_TGT_CSR+1)  per-source CSR index; source i occupies slice i.
- iw_src_wdata  in  NUM_SRC*(`HBIT_DATA+1)  per-source data; source i occupies slice i.
- iw_stall  in  1  when high, no entry is drained this cycle (CPU write collision avoidance).
- iw_ovf_clr  in  1  pulse; clears all overflow flags.
- ow_w2_en  out  1  registered write strobe to regcsr.
- ow_w2_addr  out  `HBIT_TGT_CSR+1  registered CSR index.
- ow_w2_data  out  `HBIT_DATA+1  registered data.
- ow_ovf  out  NUM_SRC  sticky per-source overflow.
- ow_idle  out  1  all FIFOs empty and ow_w2_en low.

Behaviour:
- Reset (async, iw_rst_n low):
  - All FIFOs emptied; read/write pointers and counts reset to 0.
  - Round-robin pointer reset to source 0.
  - ow_w2_en=0, ow_w2_addr=0, ow_w2_data=0, ow_ovf=0, ow_idle=1.
  - Reset mid-operation discards all pending entries; no partial write is emitted.
- Push:
  - iw_src_wen[i]=1 on a rising edge stores {addr,data} into FIFO i if it is not full.
  - All sources may push in the same cycle.
- Full:
  - A push to full FIFO i with no same-cycle pop from i is dropped, and ow_ovf[i] is set.
  - If FIFO i is popped in the same cycle, the push is accepted: count is unchanged and there is no overflow.
- Drain arbitration:
  - Each cycle with iw_stall=0, select the first non-empty FIFO searching from rr_ptr upward, modulo NUM_SRC.
  - Pop the selected FIFO; register its entry onto ow_w2_*; ow_w2_en=1 for exactly one cycle.
  - Set rr_ptr = granted index + 1 (mod NUM_SRC).
  - If nothing is granted, ow_w2_en=0, ow_w2_addr/ow_w2_data hold their last values, and rr_ptr is unchanged.
- Stall: iw_stall=1 gives ow_w2_en=0 next cycle; FIFOs still accept pushes; rr_ptr is unchanged.
- Latency: a push in cycle N into an empty FIFO, with no competition and no stall, appears as ow_w2_en high in cycle N+1. Write-through bypass is not allowed.
- Ordering: entries from a single source drain strictly in push order. No ordering is guaranteed across sources.
- Throughput: one write per cycle sustained. Round-robin means no source waits more than NUM_SRC-1 grants while it is non-empty.
- Overflow:
  - ow_ovf[i] is sticky.
  - iw_ovf_clr clears all bits next cycle.
  - If iw_ovf_clr coincides with a new overflow on source i, set wins for bit i.
- Pointer wrap: FIFO pointers are log2(DEPTH) bits plus a wrap bit. Full and empty are distinguished by the wrap bit.
- ow_idle is registered, computed from the post-update state.

Optional Feature:
- Macro CSR_W2_COALESCE_EN:
  - When defined, a push to FIFO i whose address equals the newest undrained entry of FIFO i overwrites that entry's data in place.
  - No new slot is used and ow_ovf is not set, even if the FIFO is full.
  - If that entry is being popped in the same cycle, the push is instead queued as a new entry.
- Without the macro, every accepted push consumes a slot.

Test Plan:
- Single push: src0 addr=MATH_RES0, data=24'h0FF000 at cycle N -> ow_w2_en=1, addr=MATH_RES0, data=24'h0FF000 at cycle N+1 only; ow_idle=1 at N+2.
- Simultaneous push: src0 (RES0,14) and src1 (RES1,2) in the same cycle, rr_ptr=0 -> RES0/14 then RES1/2 on consecutive cycles.
- Fairness: both sources pushing every cycle with DEPTH=4 -> grants alternate 0,1,0,1; ow_ovf sets once the input rate (2/cycle) exceeds drain (1/cycle).
- Overflow: stall high, 5 pushes to src0 -> first 4 retained, ow_ovf[0]=1; release stall -> exactly 4 writes in order. Then iw_ovf_clr -> ow_ovf=0.
- Full plus pop: src0 full, stall low, push same cycle -> accepted, no ovf, 5 writes total.
- Reset mid-drain: 3 queued, assert iw_rst_n=0 asynchronously -> ow_w2_en=0 immediately; after release, no writes emitted and ow_idle=1.
- With CSR_W2_COALESCE_EN: stall, push (STATUS,1) then (STATUS,5) -> single write STATUS/5.

Source files
------------

// File: rtl/csr_w2_merge.sv
// csr_w2_merge: merges single-cycle CSR write pulses from several engines onto
// the regcsr secondary write port (w2). Each source owns a small FIFO; a
// round-robin drain issues at most one registered w2 write per cycle.
// Optional build macro CSR_W2_COALESCE_EN: a push whose address matches the
// newest undrained entry of its FIFO overwrites that entry's data in place.

`ifndef HBIT_TGT_CSR
`define HBIT_TGT_CSR 4
`endif
`ifndef HBIT_DATA
`define HBIT_DATA 23
`endif

module csr_w2_merge #(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 4
) (
  input  logic                              iw_clk,
  input  logic                              iw_rst_n,
  input  logic [NUM_SRC-1:0]                iw_src_wen,
  input  logic [NUM_SRC*(`HBIT_TGT_CSR+1)-1:0] iw_src_waddr,
  input  logic [NUM_SRC*(`HBIT_DATA+1)-1:0]    iw_src_wdata,
  input  logic                              iw_stall,
  input  logic                              iw_ovf_clr,
  output logic                              ow_w2_en,
  output logic [`HBIT_TGT_CSR:0]            ow_w2_addr,
  output logic [`HBIT_DATA:0]               ow_w2_data,
  output logic [NUM_SRC-1:0]                ow_ovf,
  output logic                              ow_idle
);

  localparam int AW = `HBIT_TGT_CSR + 1;
  localparam int DW = `HBIT_DATA + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [AW-1:0] mem_addr [NUM_SRC][DEPTH];
  logic [DW-1:0] mem_data [NUM_SRC][DEPTH];
  logic [PW:0]   wptr     [NUM_SRC];
  logic [PW:0]   rptr     [NUM_SRC];
  logic [PW:0]   wptr_nxt [NUM_SRC];
  logic [PW:0]   rptr_nxt [NUM_SRC];
  logic [SW-1:0] rr_ptr;

  logic [NUM_SRC-1:0] empty, full, pop, push_new, merge, ovf_hit, empty_nxt;
  logic               grant_vld, pop_any;
  logic [SW-1:0]      grant_idx;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_data;
  int                 arb_idx;
`ifdef CSR_W2_COALESCE_EN
  logic [PW-1:0]      newest [NUM_SRC];
  logic [NUM_SRC-1:0] single;
`endif

  // FIFO status flags; the extra wrap bit separates full from empty
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      empty[i] = (wptr[i] == rptr[i]);
      full[i]  = (wptr[i][PW] != rptr[i][PW]) && (wptr[i][PW-1:0] == rptr[i][PW-1:0]);
    end
  end

  // Round-robin search for the first non-empty FIFO starting at rr_ptr
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    arb_idx   = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      arb_idx = (int'(rr_ptr) + k) % NUM_SRC;
      if (!grant_vld && !empty[arb_idx]) begin
        grant_vld = 1'b1;
        grant_idx = SW'(arb_idx);
      end
    end
  end

  // Pop / push / overflow decisions and next-state pointers
  always_comb begin
    pop_any = grant_vld && !iw_stall;
    for (int i = 0; i < NUM_SRC; i++) begin
      pop[i]   = pop_any && (grant_idx == SW'(i));
      merge[i] = 1'b0;
`ifdef CSR_W2_COALESCE_EN
      newest[i] = wptr[i][PW-1:0] - PW'(1);
      single[i] = ((wptr[i] - rptr[i]) == (PW+1)'(1));
      // a lone entry leaving this cycle cannot absorb the push
      merge[i]  = iw_src_wen[i] && !empty[i] &&
                  (mem_addr[i][newest[i]] == iw_src_waddr[i*AW +: AW]) &&
                  !(pop[i] && single[i]);
`endif
      push_new[i]  = iw_src_wen[i] && !merge[i] && (!full[i] || pop[i]);
      ovf_hit[i]   = iw_src_wen[i] && !merge[i] && full[i] && !pop[i];
      wptr_nxt[i]  = wptr[i] + (PW+1)'(push_new[i]);
      rptr_nxt[i]  = rptr[i] + (PW+1)'(pop[i]);
      empty_nxt[i] = (wptr_nxt[i] == rptr_nxt[i]);
    end
    sel_addr = mem_addr[grant_idx][rptr[grant_idx][PW-1:0]];
    sel_data = mem_data[grant_idx][rptr[grant_idx][PW-1:0]];
  end

  // FIFO storage; contents need no reset because the pointers gate validity
  always_ff @(posedge iw_clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push_new[i]) begin
        mem_addr[i][wptr[i][PW-1:0]] <= iw_src_waddr[i*AW +: AW];
        mem_data[i][wptr[i][PW-1:0]] <= iw_src_wdata[i*DW +: DW];
      end
`ifdef CSR_W2_COALESCE_EN
      else if (merge[i]) begin
        mem_data[i][newest[i]] <= iw_src_wdata[i*DW +: DW];
      end
`endif
    end
  end

  // Pointers, arbiter state and registered w2 outputs
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
      end
      rr_ptr     <= '0;
      ow_w2_en   <= 1'b0;
      ow_w2_addr <= '0;
      ow_w2_data <= '0;
      ow_ovf     <= '0;
      ow_idle    <= 1'b1;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        wptr[i] <= wptr_nxt[i];
        rptr[i] <= rptr_nxt[i];
      end
      ow_w2_en <= pop_any;
      if (pop_any) begin
        ow_w2_addr <= sel_addr;
        ow_w2_data <= sel_data;
        rr_ptr     <= (grant_idx == SW'(NUM_SRC - 1)) ? '0 : grant_idx + SW'(1);
      end
      // a new overflow on the same cycle as a clear keeps its bit set
      ow_ovf  <= (ow_ovf & ~{NUM_SRC{iw_ovf_clr}}) | ovf_hit;
      ow_idle <= (&empty_nxt) && !pop_any;
    end
  end

endmodule
